// File: rtl/addsub_serial_if.sv
// Operand/result handshake bundle for the digit-serial add/subtract unit.
// The producer/consumer side uses the master modport, the unit uses slave.
interface addsub_serial_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid,
        output op_a,
        output op_b,
        output sub,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  carry,
        input  overflow,
        input  zero
    );

    modport slave (
        input  in_valid,
        input  op_a,
        input  op_b,
        input  sub,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output carry,
        output overflow,
        output zero
    );
endinterface

// File: rtl/addsub_serial.sv
// Digit-serial WIDTH-bit adder/subtractor. Adds DIGIT bits per CALC cycle,
// so one operation takes N = WIDTH/DIGIT cycles between acceptance and
// out_valid. Subtraction is a + ~b + 1, with the +1 entering as carry-in.
// Result and flags are registered and only change on entry to DONE.
module addsub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    addsub_serial_if.slave bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    // Only the upper WIDTH-DIGIT result bits need to be kept between digits;
    // the newest digit is always merged in combinationally at the top.
    localparam int HI_W  = (WIDTH > DIGIT) ? (WIDTH - DIGIT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               cin_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               a_msb_r;
    logic               b_msb_r;
    logic [HI_W-1:0]    res_hi_r;

    logic [WIDTH-1:0]   result_r;
    logic               carry_r;
    logic               overflow_r;
    logic               zero_r;
    logic               in_ready_r;
    logic               out_valid_r;

    logic [DIGIT:0]     digit_sum_s;
    logic [WIDTH-1:0]   new_res_s;
    logic [HI_W-1:0]    next_hi_s;
    logic               last_s;
    logic [WIDTH-1:0]   b_in_s;

    // Two's-complement overflow: operands agree in sign, result does not.
    function automatic logic signed_overflow(input logic a_msb,
                                             input logic b_msb,
                                             input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Digit adder, last-digit detect and operand-B conditioning for subtract
    always_comb begin
        digit_sum_s = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, cin_r};
        last_s      = (cnt_r == CNT_W'(N - 1));
        if (bus.sub) begin
            b_in_s = ~bus.op_b;
        end else begin
            b_in_s = bus.op_b;
        end
    end

    // Merge the new digit in from the MSB side of the partial result
    generate
        if (WIDTH > DIGIT) begin : g_multi_digit
            assign new_res_s = {digit_sum_s[DIGIT-1:0], res_hi_r};
            assign next_hi_s = new_res_s[WIDTH-1:DIGIT];
        end else begin : g_single_digit
            assign new_res_s = digit_sum_s[DIGIT-1:0];
            assign next_hi_s = {HI_W{1'b0}};
        end
    endgenerate

    // Control FSM with datapath shift registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            cin_r       <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            a_msb_r     <= 1'b0;
            b_msb_r     <= 1'b0;
            res_hi_r    <= {HI_W{1'b0}};
            result_r    <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            overflow_r  <= 1'b0;
            zero_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        a_r        <= bus.op_a;
                        b_r        <= b_in_s;
                        cin_r      <= bus.sub;
                        cnt_r      <= {CNT_W{1'b0}};
                        // Sign bits are shifted out during CALC, keep copies
                        a_msb_r    <= bus.op_a[WIDTH-1];
                        b_msb_r    <= b_in_s[WIDTH-1];
                        in_ready_r <= 1'b0;
                        state_r    <= CALC;
                    end else begin
                        in_ready_r <= 1'b1;
                        state_r    <= IDLE;
                    end
                end
                CALC: begin
                    a_r      <= a_r >> DIGIT;
                    b_r      <= b_r >> DIGIT;
                    cin_r    <= digit_sum_s[DIGIT];
                    res_hi_r <= next_hi_s;
                    cnt_r    <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        result_r    <= new_res_s;
                        carry_r     <= digit_sum_s[DIGIT];
                        overflow_r  <= signed_overflow(a_msb_r, b_msb_r,
                                                       new_res_s[WIDTH-1]);
                        zero_r      <= (new_res_s == {WIDTH{1'b0}});
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        state_r     <= CALC;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.carry     = carry_r;
    assign bus.overflow  = overflow_r;
    assign bus.zero      = zero_r;
endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: three instances (8/2, 4/1, 16/16) share clock and
// reset and are exercised one at a time. An arithmetic reference model plus
// a cycle-accurate handshake expectation is checked on every falling edge.
module tb_addsub_serial;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    logic        in_valid_d  [3];
    logic        out_ready_d [3];
    logic        sub_d       [3];
    logic [15:0] op_a_d      [3];
    logic [15:0] op_b_d      [3];
    logic        rdy [3];
    logic        ov  [3];
    logic        cy  [3];
    logic        of  [3];
    logic        zr  [3];
    logic [15:0] res_m [3];

    addsub_serial_if #(.WIDTH(8))  bus0 ();
    addsub_serial_if #(.WIDTH(4))  bus1 ();
    addsub_serial_if #(.WIDTH(16)) bus2 ();

    addsub_serial #(.WIDTH(8),  .DIGIT(2))  dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    addsub_serial #(.WIDTH(4),  .DIGIT(1))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    addsub_serial #(.WIDTH(16), .DIGIT(16)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    assign bus0.in_valid = in_valid_d[0];
    assign bus0.op_a = op_a_d[0][7:0];
    assign bus0.op_b = op_b_d[0][7:0];
    assign bus0.sub = sub_d[0];
    assign bus0.out_ready = out_ready_d[0];
    assign rdy[0] = bus0.in_ready;
    assign ov[0] = bus0.out_valid;
    assign cy[0] = bus0.carry;
    assign of[0] = bus0.overflow;
    assign zr[0] = bus0.zero;
    assign res_m[0] = {8'h00, bus0.result};

    assign bus1.in_valid = in_valid_d[1];
    assign bus1.op_a = op_a_d[1][3:0];
    assign bus1.op_b = op_b_d[1][3:0];
    assign bus1.sub = sub_d[1];
    assign bus1.out_ready = out_ready_d[1];
    assign rdy[1] = bus1.in_ready;
    assign ov[1] = bus1.out_valid;
    assign cy[1] = bus1.carry;
    assign of[1] = bus1.overflow;
    assign zr[1] = bus1.zero;
    assign res_m[1] = {12'h000, bus1.result};

    assign bus2.in_valid = in_valid_d[2];
    assign bus2.op_a = op_a_d[2];
    assign bus2.op_b = op_b_d[2];
    assign bus2.sub = sub_d[2];
    assign bus2.out_ready = out_ready_d[2];
    assign rdy[2] = bus2.in_ready;
    assign ov[2] = bus2.out_valid;
    assign cy[2] = bus2.carry;
    assign of[2] = bus2.overflow;
    assign zr[2] = bus2.zero;
    assign res_m[2] = bus2.result;

    function automatic int wd(input int c);
        case (c)
            0:       return 8;
            1:       return 4;
            default: return 16;
        endcase
    endfunction

    function automatic int nd(input int c);
        case (c)
            0:       return 4;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic [18:0] outs(input int c);
        return {res_m[c], cy[c], of[c], zr[c]};
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic logic [18:0] model(input int c, input logic [15:0] a,
                                          input logic [15:0] b, input logic s);
        longint m, ua, ub, full, res, half, sa, sb2, r;
        logic carry, ovf, zero;
        m    = (64'd1 << wd(c)) - 64'd1;
        half = 64'd1 << (wd(c) - 1);
        ua   = longint'(a) & m;
        ub   = longint'(b) & m;
        full = s ? (ua - ub) : (ua + ub);
        res  = full & m;
        carry = s ? (ua >= ub) : (full > m);
        sa   = (ua >= half) ? (ua - (m + 64'd1)) : ua;
        sb2  = (ub >= half) ? (ub - (m + 64'd1)) : ub;
        r    = s ? (sa - sb2) : (sa + sb2);
        ovf  = (r >= half) || (r < -half);
        zero = (res == 64'd0);
        return {res[15:0], carry, ovf, zero};
    endfunction

    typedef struct {
        int          cfg;
        logic [18:0] exp;
        int          t;
    } exp_t;
    exp_t sb[$];

    // Per-cycle compare against the reference and handshake timing
    always @(negedge clk) begin
        bit has;
        bit exp_ov;
        exp_t e;
        if (!rst_n) begin
            sb.delete();
        end else begin
            for (int c = 0; c < 3; c++) begin
                has = (sb.size() > 0) && (sb[0].cfg == c);
                checks++;
                if (rdy[c] !== !has) begin
                    errors++;
                    $display("FAIL in_ready cfg%0d got %b want %b cyc %0d", c, rdy[c], !has, cyc);
                end
                exp_ov = has ? (cyc >= sb[0].t + nd(c) + 1) : 1'b0;
                checks++;
                if (ov[c] !== exp_ov) begin
                    errors++;
                    $display("FAIL out_valid cfg%0d got %b want %b cyc %0d", c, ov[c], exp_ov, cyc);
                end
                if (has && ov[c]) begin
                    checks++;
                    if (outs(c) !== sb[0].exp) begin
                        errors++;
                        $display("FAIL result_flags cfg%0d got %h want %h cyc %0d", c, outs(c), sb[0].exp, cyc);
                    end
                    if (out_ready_d[c]) void'(sb.pop_front());
                end
                if (in_valid_d[c] && rdy[c]) begin
                    e.cfg = c;
                    e.exp = model(c, op_a_d[c], op_b_d[c], sub_d[c]);
                    e.t   = cyc;
                    sb.push_back(e);
                end
            end
        end
        cyc++;
    end

    task automatic start_op(input int c, input logic [15:0] a, input logic [15:0] b, input logic s);
        int n;
        @(posedge clk); #1;
        in_valid_d[c] = 1'b1;
        op_a_d[c] = a;
        op_b_d[c] = b;
        sub_d[c] = s;
        n = 0;
        while (!rdy[c] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout cfg%0d got in_ready %b want 1", c, rdy[c]);
        end
        @(posedge clk); #1;
        in_valid_d[c] = 1'b0;
        op_a_d[c] = 16'($urandom);
        op_b_d[c] = 16'($urandom);
        sub_d[c] = 1'($urandom);
    endtask

    task automatic wait_out(input int c, input bit noise, output int lat);
        lat = 0;
        while (!ov[c] && lat < 200) begin
            if (noise) out_ready_d[c] = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        out_ready_d[c] = 1'b0;
        if (lat >= 200) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout cfg%0d got %b want 1", c, ov[c]);
        end
    endtask

    task automatic finish_out(input int c, input int stall, output logic [18:0] got);
        repeat (stall) begin
            @(posedge clk); #1;
        end
        got = outs(c);
        out_ready_d[c] = 1'b1;
        @(posedge clk); #1;
        out_ready_d[c] = 1'b0;
    endtask

    task automatic do_op(input int c, input logic [15:0] a, input logic [15:0] b, input logic s,
                         input int stall, input bit noise, output logic [18:0] got, output int lat);
        start_op(c, a, b, s);
        wait_out(c, noise, lat);
        finish_out(c, stall, got);
    endtask

    task automatic directed(input int c, input logic [15:0] a, input logic [15:0] b, input logic s,
                            input logic [15:0] er, input logic ec, input logic eo, input logic ez,
                            input string name);
        logic [18:0] e;
        logic [18:0] got;
        int lat;
        e = {er, ec, eo, ez};
        checks++;
        if (model(c, a, b, s) !== e) begin
            errors++;
            $display("FAIL model_%s got %h want %h", name, model(c, a, b, s), e);
        end
        do_op(c, a, b, s, 2, 1'b0, got, lat);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, e);
        end
        checks++;
        if (lat != nd(c)) begin
            errors++;
            $display("FAIL latency_%s got %0d want %0d", name, lat, nd(c));
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
        checks++;
        if (outs(c) !== e) begin
            errors++;
            $display("FAIL hold_%s got %h want %h", name, outs(c), e);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %b want %b", name, got, want);
        end
    endtask

    task automatic check_vec(input string name, input logic [18:0] got, input logic [18:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    initial begin
        logic [18:0] got;
        logic [18:0] held;
        int lat;
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid_d[c] = 1'b0;
            out_ready_d[c] = 1'b0;
            sub_d[c] = 1'b0;
            op_a_d[c] = 16'h0000;
            op_b_d[c] = 16'h0000;
        end
        #12;
        for (int c = 0; c < 3; c++) begin
            check_bit("reset_in_ready", rdy[c], 1'b1);
            check_bit("reset_out_valid", ov[c], 1'b0);
            check_vec("reset_outputs", outs(c), 19'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // WIDTH=8, DIGIT=2
        directed(0, 16'h03, 16'h0E, 1'b0, 16'h11, 1'b0, 1'b0, 1'b0, "w8_add_03_0e");
        directed(0, 16'hFF, 16'h01, 1'b0, 16'h00, 1'b1, 1'b0, 1'b1, "w8_add_ff_01");
        directed(0, 16'h7F, 16'h01, 1'b0, 16'h80, 1'b0, 1'b1, 1'b0, "w8_add_7f_01");
        directed(0, 16'h80, 16'h01, 1'b1, 16'h7F, 1'b1, 1'b1, 1'b0, "w8_sub_80_01");
        directed(0, 16'h05, 16'h07, 1'b1, 16'hFE, 1'b0, 1'b0, 1'b0, "w8_sub_05_07");
        // WIDTH=4, DIGIT=1
        directed(1, 16'h3, 16'hE, 1'b0, 16'h1, 1'b1, 1'b0, 1'b0, "w4_add_3_e");
        directed(1, 16'hF, 16'h1, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1, "w4_add_f_1");
        directed(1, 16'h7, 16'h1, 1'b0, 16'h8, 1'b0, 1'b1, 1'b0, "w4_add_7_1");
        directed(1, 16'h8, 16'h1, 1'b1, 16'h7, 1'b1, 1'b1, 1'b0, "w4_sub_8_1");
        directed(1, 16'h5, 16'h7, 1'b1, 16'hE, 1'b0, 1'b0, 1'b0, "w4_sub_5_7");
        // WIDTH=16, DIGIT=16
        directed(2, 16'h0003, 16'h000E, 1'b0, 16'h0011, 1'b0, 1'b0, 1'b0, "w16_add_3_e");
        directed(2, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, "w16_add_ffff_1");
        directed(2, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, "w16_add_7fff_1");
        directed(2, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, "w16_sub_8000_1");
        directed(2, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, "w16_sub_5_7");

        // Backpressure with a pending operand set waiting in front
        start_op(0, 16'h12, 16'h34, 1'b0);
        wait_out(0, 1'b0, lat);
        held = {16'h0046, 1'b0, 1'b0, 1'b0};
        in_valid_d[0] = 1'b1;
        op_a_d[0] = 16'h20;
        op_b_d[0] = 16'h22;
        sub_d[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_bit("bp_in_ready_low", rdy[0], 1'b0);
            check_vec("bp_outputs_stable", outs(0), held);
        end
        out_ready_d[0] = 1'b1;
        @(posedge clk); #1;
        out_ready_d[0] = 1'b0;
        check_bit("bp_in_ready_rise", rdy[0], 1'b1);
        check_bit("bp_out_valid_fall", ov[0], 1'b0);
        @(posedge clk); #1;
        check_bit("bp_pending_accepted", rdy[0], 1'b0);
        in_valid_d[0] = 1'b0;
        wait_out(0, 1'b0, lat);
        check_bit("bp_latency", (lat == 4), 1'b1);
        finish_out(0, 0, got);
        check_vec("bp_second_result", got, {16'h0042, 1'b0, 1'b0, 1'b0});

        // Asynchronous reset in the second CALC cycle
        start_op(0, 16'h55, 16'h22, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_bit("rst_mid_in_ready", rdy[0], 1'b1);
        check_bit("rst_mid_out_valid", ov[0], 1'b0);
        check_vec("rst_mid_outputs", outs(0), 19'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        directed(0, 16'h10, 16'h20, 1'b0, 16'h30, 1'b0, 1'b0, 1'b0, "after_reset_10_20");

        // Random operands, random stalls, out_ready noise during CALC
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 1000; i++) begin
                do_op(c, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), 1'b1, got, lat);
                checks++;
                if (lat != nd(c)) begin
                    errors++;
                    $display("FAIL rand_latency cfg%0d got %0d want %0d", c, lat, nd(c));
                end
            end
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
